output_ports: RTL and testbench

//  Output-side counterpart of the processor's 4-pin port interface: drives four

---
 rtl/output_ports_pkg.sv | 27 ++
 rtl/output_ports_timer.sv | 28 ++
 rtl/output_ports.sv | 172 +++++++++++++++++
 tb/tb_output_ports.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/output_ports_pkg.sv
// Shared types and constants for the output_ports block.
// Optional feature macro: OUTPUT_PULSE_EN adds the PULSE state.
package output_ports_pkg;

`ifdef OUTPUT_PULSE_EN
    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        PULSE,
        SETTLE,
        DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        DONE
    } state_t;
`endif

    localparam logic [1:0] PIN_D0 = 2'b00;
    localparam logic [1:0] PIN_D1 = 2'b01;
    localparam logic [1:0] PIN_D2 = 2'b10;
    localparam logic [1:0] PIN_D3 = 2'b11;

endpackage

// File: rtl/output_ports_timer.sv
// Down-counter shared by the settle and pulse windows of output_ports.
// Loads on request, otherwise counts down and parks at zero.
module out_port_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load takes priority; otherwise decrement until zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/output_ports.sv
// Four registered output pins driven by processor write commands.
// Each write: apply bit, hold a settle window, then a one-cycle ack.
// Optional feature macro: OUTPUT_PULSE_EN (pulse-mode writes that restore
// the pin's prior value after PULSE_LEN cycles).
module output_ports
    import output_ports_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
`ifdef OUTPUT_PULSE_EN
    parameter int PULSE_LEN     = 4,
`endif
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] pin_out,
    input  logic       data,
`ifdef OUTPUT_PULSE_EN
    input  logic       pulse,
`endif
    output logic       busy,
    output logic       ack,
    output logic       D0,
    output logic       D1,
    output logic       D2,
    output logic       D3
);

    localparam logic [CNT_W-1:0] SETTLE_LD =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
`ifdef OUTPUT_PULSE_EN
    localparam logic [CNT_W-1:0] PULSE_LD =
        CNT_W'((PULSE_LEN > 0) ? PULSE_LEN - 1 : 0);
`endif

    state_t           state, next_state;
    logic [3:0]       pins;
    logic [1:0]       cmd_pin;
    logic             cmd_data;
`ifdef OUTPUT_PULSE_EN
    logic             cmd_pulse;
    logic             prior;
    logic             do_restore;
`endif
    logic             do_capture;
    logic             do_apply;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    out_port_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, timer control and status outputs.
    always_comb begin
        next_state = state;
        do_capture = 1'b0;
        do_apply   = 1'b0;
`ifdef OUTPUT_PULSE_EN
        do_restore = 1'b0;
`endif
        tmr_load   = 1'b0;
        tmr_val    = '0;
        busy       = (state != IDLE);
        ack        = (state == DONE);
        case (state)
            IDLE: begin
                if (wr_en) begin
                    do_capture = 1'b1;
                    next_state = APPLY;
                end
            end
            APPLY: begin
                do_apply = 1'b1;
`ifdef OUTPUT_PULSE_EN
                if (cmd_pulse) begin
                    tmr_load   = 1'b1;
                    tmr_val    = PULSE_LD;
                    next_state = PULSE;
                end else
`endif
                if (SETTLE_CYCLES == 0) begin
                    next_state = DONE;
                end else begin
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_LD;
                    next_state = SETTLE;
                end
            end
`ifdef OUTPUT_PULSE_EN
            PULSE: begin
                if (tmr_zero) begin
                    do_restore = 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        next_state = DONE;
                    end else begin
                        tmr_load   = 1'b1;
                        tmr_val    = SETTLE_LD;
                        next_state = SETTLE;
                    end
                end
            end
`endif
            SETTLE: begin
                if (tmr_zero) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command capture and pin registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pins     <= '0;
            cmd_pin  <= '0;
            cmd_data <= 1'b0;
`ifdef OUTPUT_PULSE_EN
            cmd_pulse <= 1'b0;
            prior     <= 1'b0;
`endif
        end else begin
            if (do_capture) begin
                cmd_pin  <= pin_out;
                cmd_data <= data;
`ifdef OUTPUT_PULSE_EN
                cmd_pulse <= pulse;
`endif
            end
            if (do_apply) begin
                pins[cmd_pin] <= cmd_data;
`ifdef OUTPUT_PULSE_EN
                prior <= pins[cmd_pin];
`endif
            end
`ifdef OUTPUT_PULSE_EN
            if (do_restore) begin
                pins[cmd_pin] <= prior;
            end
`endif
        end
    end

    assign D0 = pins[PIN_D0];
    assign D1 = pins[PIN_D1];
    assign D2 = pins[PIN_D2];
    assign D3 = pins[PIN_D3];

endmodule

// File: tb/tb_output_ports.sv
// Directed bench for output_ports: default instance plus a SETTLE_CYCLES=0 one.
module tb_output_ports;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, wr_en0 = 1'b0;
    logic [1:0] pin_out = 2'b00, pin_out0 = 2'b00;
    logic       data = 1'b0, data0 = 1'b0;
`ifdef OUTPUT_PULSE_EN
    logic       pulse = 1'b0, pulse0 = 1'b0;
`endif
    logic       busy, ack, D0, D1, D2, D3;
    logic       busy0, ack0, E0, E1, E2, E3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    output_ports dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .pin_out(pin_out), .data(data),
`ifdef OUTPUT_PULSE_EN
        .pulse(pulse),
`endif
        .busy(busy), .ack(ack), .D0(D0), .D1(D1), .D2(D2), .D3(D3)
    );

    output_ports #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en0), .pin_out(pin_out0), .data(data0),
`ifdef OUTPUT_PULSE_EN
        .pulse(pulse0),
`endif
        .busy(busy0), .ack(ack0), .D0(E0), .D1(E1), .D2(E2), .D3(E3)
    );

    typedef struct {
        logic [1:0] pin;
        logic       bitv;
        logic [3:0] exp;   // {D3,D2,D1,D0} after the write
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int dpins();
        return int'({D3, D2, D1, D0});
    endfunction

    initial begin
        logic [3:0] prev;
        int acks;

        vecs[0] = '{2'b10, 1'b1, 4'b0100};
        vecs[1] = '{2'b01, 1'b1, 4'b0110};
        vecs[2] = '{2'b01, 1'b0, 4'b0100};
        vecs[3] = '{2'b00, 1'b1, 4'b0101};
        vecs[4] = '{2'b11, 1'b1, 4'b1101};
        vecs[5] = '{2'b11, 1'b1, 4'b1101};
        vecs[6] = '{2'b10, 1'b0, 4'b1001};
        vecs[7] = '{2'b00, 1'b0, 4'b1000};

        // Reset state.
        step();
        step();
        rst = 1'b0;
        chk("reset_pins", dpins(), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ack", int'(ack), 0);
        chk("reset_pins0", int'({E3, E2, E1, E0}), 0);

        // Level writes, one full sequence per vector.
        for (int i = 0; i < 8; i++) begin
            prev = (i == 0) ? 4'b0000 : vecs[i-1].exp;
            wr_en = 1'b1; pin_out = vecs[i].pin; data = vecs[i].bitv;
            step();                                   // cycle 1
            wr_en = 1'b0;
            chk($sformatf("v%0d_c1_pins", i), dpins(), int'(prev));
            chk($sformatf("v%0d_c1_busy", i), int'(busy), 1);
            chk($sformatf("v%0d_c1_ack", i), int'(ack), 0);
            step();                                   // cycle 2
            chk($sformatf("v%0d_c2_pins", i), dpins(), int'(vecs[i].exp));
            chk($sformatf("v%0d_c2_ack", i), int'(ack), 0);
            step();                                   // cycle 3
            chk($sformatf("v%0d_c3_busy", i), int'(busy), 1);
            chk($sformatf("v%0d_c3_ack", i), int'(ack), 0);
            step();                                   // cycle 4
            chk($sformatf("v%0d_c4_ack", i), int'(ack), 1);
            chk($sformatf("v%0d_c4_busy", i), int'(busy), 1);
            step();                                   // cycle 5
            chk($sformatf("v%0d_c5_ack", i), int'(ack), 0);
            chk($sformatf("v%0d_c5_busy", i), int'(busy), 0);
            chk($sformatf("v%0d_c5_pins", i), dpins(), int'(vecs[i].exp));
        end

        // wr_en held for cycles 0..3 with different pins: only the first counts.
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            wr_en = 1'b1; pin_out = 2'(c); data = 1'b1;
            step();
            if (ack) acks++;
            if (c == 3) chk("busy_ign_ack_cycle", int'(ack), 1);
        end
        wr_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (ack) acks++;
        end
        chk("busy_ign_acks", acks, 1);
        chk("busy_ign_pins", dpins(), 4'b1001);
        chk("busy_ign_idle", int'(busy), 0);

        // Reset in cycle 3 of a write to D3.
        wr_en = 1'b1; pin_out = 2'b11; data = 1'b0;
        step();                                       // cycle 1
        wr_en = 1'b0;
        step();                                       // cycle 2
        chk("rst_mid_c2_pins", dpins(), 4'b0001);
        step();                                       // cycle 3
        rst = 1'b1;
        step();                                       // cycle 4
        chk("rst_mid_pins", dpins(), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ack", int'(ack), 0);
        rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (ack) acks++;
        end
        chk("rst_mid_no_ack", acks, 0);

        // SETTLE_CYCLES=0 instance: write D0=1.
        wr_en0 = 1'b1; pin_out0 = 2'b00; data0 = 1'b1;
        step();                                       // cycle 1
        wr_en0 = 1'b0;
        chk("s0_c1_busy", int'(busy0), 1);
        chk("s0_c1_ack", int'(ack0), 0);
        chk("s0_c1_d0", int'(E0), 0);
        step();                                       // cycle 2
        chk("s0_c2_d0", int'(E0), 1);
        chk("s0_c2_ack", int'(ack0), 1);
        step();                                       // cycle 3
        chk("s0_c3_ack", int'(ack0), 0);
        chk("s0_c3_busy", int'(busy0), 0);
        chk("s0_c3_pins", int'({E3, E2, E1, E0}), 4'b0001);

`ifdef OUTPUT_PULSE_EN
        // Pulse write D1=1 from D1=0: high in cycles 2-5, ack in cycle 8.
        wr_en = 1'b1; pin_out = 2'b01; data = 1'b1; pulse = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            wr_en = 1'b0; pulse = 1'b0;
            chk($sformatf("pulse_c%0d_d1", c), int'(D1), (c >= 2 && c <= 5) ? 1 : 0);
            chk($sformatf("pulse_c%0d_ack", c), int'(ack), (c == 8) ? 1 : 0);
            chk($sformatf("pulse_c%0d_busy", c), int'(busy), (c <= 8) ? 1 : 0);
        end
        chk("pulse_other_pins", int'({D3, D2, D0}), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
